// File: rtl/gelato_types.sv
// Shared types for the gelato register-collect path: widths, entry states and
// small helpers used by the operand collector and its arbiters.
`ifndef COLLECTOR_SIZE
`define COLLECTOR_SIZE 4
`endif
`ifndef BANK_NUM
`define BANK_NUM 4
`endif

package gelato_types;
  localparam int COLLECTOR_SIZE = `COLLECTOR_SIZE;
  localparam int BANK_NUM       = `BANK_NUM;
  localparam int OPERAND_NUM    = 4;
  localparam int WARP_COUNT     = 32;
  localparam int REG_COUNT      = 64;
  localparam int WARP_SIZE      = 4;
  localparam int DATA_WIDTH     = 32;
  localparam int WARP_REG_WIDTH = WARP_SIZE * DATA_WIDTH;

  typedef logic [$clog2(WARP_COUNT)-1:0]     warp_num_t;
  typedef logic [$clog2(REG_COUNT)-1:0]      reg_num_t;
  typedef logic [WARP_REG_WIDTH-1:0]         warp_reg_t;
  typedef logic [$clog2(COLLECTOR_SIZE)-1:0] collector_num_t;
  typedef logic [$clog2(OPERAND_NUM)-1:0]    rs_num_t;

  typedef enum logic [1:0] {
    FREE       = 2'd0,
    COLLECTING = 2'd1,
    READY      = 2'd2
  } collector_state_t;

  function automatic collector_num_t onehot_to_collector(input logic [COLLECTOR_SIZE-1:0] onehot);
    collector_num_t idx;
    idx = '0;
    for (int i = 0; i < COLLECTOR_SIZE; i++)
      if (onehot[i]) idx = collector_num_t'(i);
    return idx;
  endfunction
endpackage

// File: rtl/gelato_register_collect_if.sv
// Collect-request (collector -> RF arbiter) and collect-response (banks ->
// collector) interfaces.
interface gelato_register_collect_request_if;
  import gelato_types::*;
  logic                      valid;
  logic [COLLECTOR_SIZE-1:0] entry_valid;
  warp_num_t                 warp_num      [COLLECTOR_SIZE];
  reg_num_t                  reg_num       [COLLECTOR_SIZE][OPERAND_NUM];
  logic [OPERAND_NUM-1:0]    reg_valid     [COLLECTOR_SIZE];
  collector_num_t            collector_num [COLLECTOR_SIZE];

  modport master (output valid, entry_valid, warp_num, reg_num, reg_valid, collector_num);
  modport slave  (input  valid, entry_valid, warp_num, reg_num, reg_valid, collector_num);
endinterface

interface gelato_register_collect_response_if;
  import gelato_types::*;
  logic                valid;
  logic [BANK_NUM-1:0] data_valid;
  collector_num_t      collector_index [BANK_NUM];
  rs_num_t             reg_index       [BANK_NUM];
  warp_reg_t           data            [BANK_NUM];

  modport master (output valid, data_valid, collector_index, reg_index, data);
  modport slave  (input  valid, data_valid, collector_index, reg_index, data);
endinterface

// File: rtl/gelato_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, pointer moves past the winner on advance.
// An un-advanced grant is held so the consumer sees a stable choice.
module gelato_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] request,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr_reg;
  logic [IW-1:0] ptr_next;
  logic [IW-1:0] scan_idx;
  logic [IW-1:0] grant_idx;
  logic [N-1:0]  rr_grant;
  logic [N-1:0]  hold_grant_reg;
  logic          hold_reg;

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    rr_grant = '0;
    scan_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      scan_idx = IW'((int'(ptr_reg) + k) % N);
      if (request[scan_idx]) begin
        rr_grant           = '0;
        rr_grant[scan_idx] = 1'b1;
      end
    end
  end

  assign grant = (hold_reg && |(hold_grant_reg & request)) ? hold_grant_reg : rr_grant;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N; i++)
      if (grant[i]) grant_idx = IW'(i);
  end

  assign ptr_next = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg        <= '0;
      hold_reg       <= 1'b0;
      hold_grant_reg <= '0;
    end else begin
      hold_reg       <= |grant && !advance;
      hold_grant_reg <= grant;
      if (advance && |grant) ptr_reg <= ptr_next;
    end
  end
endmodule

// File: rtl/gelato_operand_collector.sv
// Operand collector: holds issued instructions, publishes pending source
// registers, absorbs bank responses and dispatches complete instructions.
module gelato_operand_collector
  import gelato_types::*;
#(
  parameter int INST_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  warp_num_t              issue_warp_num,
  input  reg_num_t               issue_reg_num [OPERAND_NUM],
  input  logic [OPERAND_NUM-1:0] issue_reg_valid,
  input  logic [INST_WIDTH-1:0]  issue_inst,
  gelato_register_collect_request_if.master req,
  gelato_register_collect_response_if.slave rsp,
  output logic                   dispatch_valid,
  input  logic                   dispatch_ready,
  output warp_num_t              dispatch_warp_num,
  output warp_reg_t              dispatch_operand [OPERAND_NUM],
  output logic [INST_WIDTH-1:0]  dispatch_inst,
  output collector_num_t         dispatch_collector
);
  localparam int C = COLLECTOR_SIZE;

  logic [C-1:0]          free_vec;
  logic [C-1:0]          collecting_vec;
  logic [C-1:0]          ready_vec;
  logic [C-1:0]          alloc_sel;
  logic [C-1:0]          dispatch_grant;
  logic                  alloc_fire;
  logic                  dispatch_fire;
  collector_num_t        grant_idx;
  warp_num_t             entry_warp [C];
  logic [INST_WIDTH-1:0] entry_inst [C];
  warp_reg_t             entry_data [C][OPERAND_NUM];

  assign issue_ready = |free_vec;
  assign alloc_fire  = issue_valid && issue_ready;
  // Isolate the lowest set bit: lowest-index free entry.
  assign alloc_sel   = free_vec & (~free_vec + C'(1));

  for (genvar gi = 0; gi < C; gi++) begin : g_entry
    collector_state_t       state_reg, state_next;
    warp_num_t              warp_reg, warp_next;
    reg_num_t               reg_num_reg [OPERAND_NUM];
    reg_num_t               reg_num_next [OPERAND_NUM];
    logic [OPERAND_NUM-1:0] pending_reg, pending_next;
    warp_reg_t              data_reg [OPERAND_NUM];
    warp_reg_t              data_next [OPERAND_NUM];
    logic [INST_WIDTH-1:0]  inst_reg, inst_next;
    logic                   alloc_here;

    assign alloc_here = alloc_fire && alloc_sel[gi];

    always_comb begin
      state_next   = state_reg;
      warp_next    = warp_reg;
      reg_num_next = reg_num_reg;
      pending_next = pending_reg;
      data_next    = data_reg;
      inst_next    = inst_reg;
      if (alloc_here) begin
        warp_next    = issue_warp_num;
        reg_num_next = issue_reg_num;
        pending_next = issue_reg_valid;
        inst_next    = issue_inst;
        for (int k = 0; k < OPERAND_NUM; k++) data_next[k] = '0;
        state_next   = (|issue_reg_valid) ? COLLECTING : READY;
      end else if (state_reg == COLLECTING) begin
        // Later banks overwrite earlier ones on a shared slot.
        for (int b = 0; b < BANK_NUM; b++) begin
          if (rsp.valid && rsp.data_valid[b] &&
              rsp.collector_index[b] == collector_num_t'(gi) &&
              pending_reg[rsp.reg_index[b]]) begin
            data_next[rsp.reg_index[b]]    = rsp.data[b];
            pending_next[rsp.reg_index[b]] = 1'b0;
          end
        end
        if (pending_next == '0) state_next = READY;
      end else if (state_reg == READY && dispatch_fire && dispatch_grant[gi]) begin
        state_next = FREE;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_reg   <= FREE;
        warp_reg    <= '0;
        pending_reg <= '0;
        inst_reg    <= '0;
        for (int k = 0; k < OPERAND_NUM; k++) begin
          reg_num_reg[k] <= '0;
          data_reg[k]    <= '0;
        end
      end else begin
        state_reg   <= state_next;
        warp_reg    <= warp_next;
        pending_reg <= pending_next;
        inst_reg    <= inst_next;
        for (int k = 0; k < OPERAND_NUM; k++) begin
          reg_num_reg[k] <= reg_num_next[k];
          data_reg[k]    <= data_next[k];
        end
      end
    end

    assign free_vec[gi]       = (state_reg == FREE);
    assign collecting_vec[gi] = (state_reg == COLLECTING);
    assign ready_vec[gi]      = (state_reg == READY);
    assign entry_warp[gi]     = warp_reg;
    assign entry_inst[gi]     = inst_reg;
    assign entry_data[gi]     = data_reg;

    assign req.entry_valid[gi]   = collecting_vec[gi];
    assign req.warp_num[gi]      = warp_reg;
    assign req.reg_num[gi]       = reg_num_reg;
    assign req.reg_valid[gi]     = collecting_vec[gi] ? pending_reg : '0;
    assign req.collector_num[gi] = collector_num_t'(gi);
  end

  assign req.valid = |collecting_vec;

  gelato_rr_arbiter #(.N(C)) u_dispatch_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .request (ready_vec),
    .advance (dispatch_fire),
    .grant   (dispatch_grant)
  );

  assign grant_idx      = onehot_to_collector(dispatch_grant);
  assign dispatch_valid = |ready_vec;
  assign dispatch_fire  = dispatch_valid && dispatch_ready;

  always_comb begin
    dispatch_warp_num  = '0;
    dispatch_inst      = '0;
    dispatch_collector = '0;
    for (int k = 0; k < OPERAND_NUM; k++) dispatch_operand[k] = '0;
    if (dispatch_valid) begin
      dispatch_warp_num  = entry_warp[grant_idx];
      dispatch_inst      = entry_inst[grant_idx];
      dispatch_collector = grant_idx;
      for (int k = 0; k < OPERAND_NUM; k++) dispatch_operand[k] = entry_data[grant_idx][k];
    end
  end
endmodule

// File: tb/tb_gelato_operand_collector.sv
// Bench for gelato_operand_collector: directed scenarios plus random traffic,
// all checked against an entry-level behavioural model.
module tb_gelato_operand_collector;
  import gelato_types::*;

  localparam int C  = COLLECTOR_SIZE;
  localparam int B  = BANK_NUM;
  localparam int K  = OPERAND_NUM;
  localparam int IW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                   issue_valid;
  logic                   issue_ready;
  warp_num_t              issue_warp_num;
  reg_num_t               issue_reg_num [K];
  logic [K-1:0]           issue_reg_valid;
  logic [IW-1:0]          issue_inst;
  logic                   dispatch_valid;
  logic                   dispatch_ready;
  warp_num_t              dispatch_warp_num;
  warp_reg_t              dispatch_operand [K];
  logic [IW-1:0]          dispatch_inst;
  collector_num_t         dispatch_collector;

  gelato_register_collect_request_if  req_if ();
  gelato_register_collect_response_if rsp_if ();

  gelato_operand_collector #(.INST_WIDTH(IW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .issue_valid        (issue_valid),
    .issue_ready        (issue_ready),
    .issue_warp_num     (issue_warp_num),
    .issue_reg_num      (issue_reg_num),
    .issue_reg_valid    (issue_reg_valid),
    .issue_inst         (issue_inst),
    .req                (req_if),
    .rsp                (rsp_if),
    .dispatch_valid     (dispatch_valid),
    .dispatch_ready     (dispatch_ready),
    .dispatch_warp_num  (dispatch_warp_num),
    .dispatch_operand   (dispatch_operand),
    .dispatch_inst      (dispatch_inst),
    .dispatch_collector (dispatch_collector)
  );

  int vectors = 0;
  int miscompares = 0;
  int strays = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model: entry life-cycle 0=free, 1=collecting, 2=ready.
  int            m_state [C];
  warp_num_t     m_warp  [C];
  reg_num_t      m_regs  [C][K];
  logic [K-1:0]  m_pend  [C];
  warp_reg_t     m_data  [C][K];
  logic [IW-1:0] m_inst  [C];
  int            m_ptr;
  int            m_hold;

  function automatic void model_reset();
    for (int i = 0; i < C; i++) begin
      m_state[i] = 0;
      m_pend[i]  = '0;
      m_warp[i]  = '0;
      m_inst[i]  = '0;
      for (int k = 0; k < K; k++) begin
        m_data[i][k] = '0;
        m_regs[i][k] = '0;
      end
    end
    m_ptr  = 0;
    m_hold = -1;
  endfunction

  // Entry the collector should be presenting, or -1.
  function automatic int model_pick();
    if (m_hold >= 0) return m_hold;
    for (int k = 0; k < C; k++) begin
      int j = (m_ptr + k) % C;
      if (m_state[j] == 2) return j;
    end
    return -1;
  endfunction

  function automatic bit model_any(input int st);
    for (int i = 0; i < C; i++) if (m_state[i] == st) return 1'b1;
    return 1'b0;
  endfunction

  task automatic compare_all();
    int p;
    p = model_pick();
    check("issue_ready", issue_ready, model_any(0));
    check("req_valid", req_if.valid, model_any(1));
    for (int i = 0; i < C; i++) begin
      check($sformatf("entry_valid[%0d]", i), req_if.entry_valid[i], m_state[i] == 1);
      check($sformatf("reg_valid[%0d]", i), req_if.reg_valid[i], (m_state[i] == 1) ? m_pend[i] : '0);
      check($sformatf("collector_num[%0d]", i), req_if.collector_num[i], i);
      if (m_state[i] == 1) begin
        check($sformatf("req_warp[%0d]", i), req_if.warp_num[i], m_warp[i]);
        for (int k = 0; k < K; k++)
          check($sformatf("req_reg[%0d][%0d]", i, k), req_if.reg_num[i][k], m_regs[i][k]);
      end
    end
    check("dispatch_valid", dispatch_valid, p >= 0);
    if (p >= 0) begin
      check("dispatch_collector", dispatch_collector, p);
      check("dispatch_warp", dispatch_warp_num, m_warp[p]);
      check("dispatch_inst", dispatch_inst, m_inst[p]);
      for (int k = 0; k < K; k++)
        check($sformatf("dispatch_operand[%0d]", k), dispatch_operand[k], m_data[p][k]);
    end
  endtask

  task automatic model_update();
    int p;
    int f;
    int ci;
    int ri;
    int state0 [C];
    logic [K-1:0] pend0 [C];
    p      = model_pick();
    state0 = m_state;
    pend0  = m_pend;
    f = -1;
    for (int i = C - 1; i >= 0; i--) if (state0[i] == 0) f = i;
    if (p >= 0) begin
      if (dispatch_ready) begin
        $display("dispatch collector=%0d warp=%0d inst=0x%0h", p, m_warp[p], m_inst[p]);
        m_state[p] = 0;
        m_ptr      = (p + 1) % C;
        m_hold     = -1;
      end else begin
        m_hold = p;
      end
    end
    if (rsp_if.valid) begin
      for (int b = 0; b < B; b++) begin
        if (rsp_if.data_valid[b]) begin
          ci = int'(rsp_if.collector_index[b]);
          ri = int'(rsp_if.reg_index[b]);
          if (state0[ci] == 1 && pend0[ci][ri]) begin
            m_data[ci][ri] = rsp_if.data[b];
            m_pend[ci][ri] = 1'b0;
          end else begin
            strays++;
            $display("protocol: stray response bank=%0d entry=%0d slot=%0d ignored", b, ci, ri);
          end
        end
      end
    end
    for (int i = 0; i < C; i++)
      if (state0[i] == 1 && m_pend[i] == '0) m_state[i] = 2;
    if (issue_valid && f >= 0) begin
      $display("issue entry=%0d warp=%0d reg_valid=%b inst=0x%0h", f, issue_warp_num, issue_reg_valid, issue_inst);
      m_warp[f] = issue_warp_num;
      m_inst[f] = issue_inst;
      m_pend[f] = issue_reg_valid;
      for (int k = 0; k < K; k++) begin
        m_regs[f][k] = issue_reg_num[k];
        m_data[f][k] = '0;
      end
      m_state[f] = (issue_reg_valid != '0) ? 1 : 2;
    end
  endtask

  // Inputs are set at posedge+1; outputs are checked at the following negedge.
  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    issue_valid     = 1'b0;
    issue_warp_num  = '0;
    issue_reg_valid = '0;
    issue_inst      = '0;
    dispatch_ready  = 1'b0;
    for (int k = 0; k < K; k++) issue_reg_num[k] = '0;
    rsp_if.valid      = 1'b0;
    rsp_if.data_valid = '0;
    for (int b = 0; b < B; b++) begin
      rsp_if.collector_index[b] = '0;
      rsp_if.reg_index[b]       = '0;
      rsp_if.data[b]            = '0;
    end
  endtask

  task automatic set_issue(input int warp, input int r0, input int r1, input int r2, input int r3,
                           input logic [K-1:0] rv, input logic [IW-1:0] inst);
    issue_valid      = 1'b1;
    issue_warp_num   = warp_num_t'(warp);
    issue_reg_num[0] = reg_num_t'(r0);
    issue_reg_num[1] = reg_num_t'(r1);
    issue_reg_num[2] = reg_num_t'(r2);
    issue_reg_num[3] = reg_num_t'(r3);
    issue_reg_valid  = rv;
    issue_inst       = inst;
  endtask

  task automatic set_rsp(input int b, input int ci, input int ri, input warp_reg_t d);
    rsp_if.valid              = 1'b1;
    rsp_if.data_valid[b]      = 1'b1;
    rsp_if.collector_index[b] = collector_num_t'(ci);
    rsp_if.reg_index[b]       = rs_num_t'(ri);
    rsp_if.data[b]            = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    #1;
    check("rst_issue_ready", issue_ready, 1'b1);
    check("rst_req_valid", req_if.valid, 1'b0);
    check("rst_dispatch_valid", dispatch_valid, 1'b0);
    check("rst_dispatch_collector", dispatch_collector, 0);
    check("rst_dispatch_inst", dispatch_inst, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int order [3] = '{0, 1, 3};
  int cand_c [$];
  int cand_r [$];
  int pick;

  initial begin
    clear_inputs();
    do_reset();

    // Single instruction, two banks answering in the same cycle.
    set_issue(2, 5, 9, 0, 0, 4'b0011, 64'h1111);
    step(); clear_inputs();
    check("single_reg_valid", req_if.reg_valid[0], 4'b0011);
    set_rsp(1, 0, 0, 'hA);
    set_rsp(3, 0, 1, 'hB);
    step(); clear_inputs();
    check("single_dv", dispatch_valid, 1'b1);
    check("single_op0", dispatch_operand[0], 'hA);
    check("single_op1", dispatch_operand[1], 'hB);
    check("single_op2", dispatch_operand[2], 0);
    check("single_coll", dispatch_collector, 0);
    dispatch_ready = 1'b1;
    step(); clear_inputs();

    // Fill, refuse a fifth issue, free entry 2 and reuse it.
    for (int n = 0; n < 4; n++) begin
      set_issue(n + 4, n, 0, 0, 0, 4'b0001, IW'(n));
      step();
    end
    check("fill_issue_ready", issue_ready, 1'b0);
    step(); clear_inputs();
    set_rsp(0, 2, 0, 'h22);
    step(); clear_inputs();
    check("fill_dispatch_coll", dispatch_collector, 2);
    dispatch_ready = 1'b1;
    step(); clear_inputs();
    check("fill_reuse_ready", issue_ready, 1'b1);
    set_issue(7, 3, 0, 0, 0, 4'b0010, 64'h77);
    step(); clear_inputs();
    check("fill_reuse_entry", req_if.entry_valid[2], 1'b1);
    check("fill_reuse_warp", req_if.warp_num[2], 7);

    // Backpressure and round-robin order.
    do_reset();
    for (int n = 0; n < 4; n++) begin
      set_issue(n + 10, n + 20, 0, 0, 0, 4'b0001, IW'(n + 100));
      step();
    end
    clear_inputs();
    set_rsp(0, 0, 0, 'h100);
    set_rsp(1, 1, 0, 'h101);
    set_rsp(3, 3, 0, 'h103);
    step(); clear_inputs();
    for (int n = 0; n < 5; n++) begin
      check("bp_hold_coll", dispatch_collector, 0);
      step();
    end
    dispatch_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      check("bp_order", dispatch_collector, order[j]);
      step();
    end
    clear_inputs();

    // Stray response and same-slot collision.
    set_rsp(0, 3, 0, 'hDEAD);
    step(); clear_inputs();
    check("stray_entry3", req_if.entry_valid[3], 1'b0);
    check("stray_dv", dispatch_valid, 1'b0);
    set_rsp(0, 2, 0, 'h1);
    set_rsp(2, 2, 0, 'h2);
    step(); clear_inputs();
    check("collide_op0", dispatch_operand[0], 'h2);
    dispatch_ready = 1'b1;
    step(); clear_inputs();

    // Zero-operand issue.
    set_issue(3, 0, 0, 0, 0, 4'b0000, 64'h55);
    step(); clear_inputs();
    check("zero_entry_valid", req_if.entry_valid, 0);
    check("zero_dv", dispatch_valid, 1'b1);
    dispatch_ready = 1'b1;
    step(); clear_inputs();

    // Reset with two entries collecting; a response arrives during reset.
    set_issue(1, 1, 2, 3, 4, 4'b1111, 64'hA1);
    step();
    set_issue(2, 5, 6, 7, 8, 4'b1111, 64'hA2);
    step(); clear_inputs();
    check("mid_req_valid_pre", req_if.valid, 1'b1);
    rst_n = 1'b0;
    set_rsp(0, 0, 0, 'h5);
    #1;
    check("mid_req_valid", req_if.valid, 1'b0);
    check("mid_issue_ready", issue_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    model_reset();
    @(posedge clk);
    #1;
    step();
    check("mid_post_ready", issue_ready, 1'b1);
    check("mid_post_dv", dispatch_valid, 1'b0);

    // Random traffic.
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      clear_inputs();
      if ($urandom_range(2, 0) != 0) begin
        set_issue($urandom_range(WARP_COUNT - 1, 0), $urandom_range(REG_COUNT - 1, 0),
                  $urandom_range(REG_COUNT - 1, 0), $urandom_range(REG_COUNT - 1, 0),
                  $urandom_range(REG_COUNT - 1, 0),
                  ($urandom_range(7, 0) == 0) ? 4'b0000 : K'($urandom_range(15, 0)),
                  {$urandom, $urandom});
      end
      dispatch_ready = ($urandom_range(2, 0) != 0);
      cand_c.delete();
      cand_r.delete();
      for (int i = 0; i < C; i++)
        for (int k = 0; k < K; k++)
          if (m_state[i] == 1 && m_pend[i][k]) begin
            cand_c.push_back(i);
            cand_r.push_back(k);
          end
      if ($urandom_range(1, 0) != 0) begin
        rsp_if.valid = 1'b1;
        for (int b = 0; b < B; b++) begin
          if ($urandom_range(1, 0) != 0) begin
            if (cand_c.size() > 0 && $urandom_range(9, 0) != 0) begin
              pick = $urandom_range(cand_c.size() - 1, 0);
              set_rsp(b, cand_c[pick], cand_r[pick], {$urandom, $urandom, $urandom, $urandom});
            end else begin
              set_rsp(b, $urandom_range(C - 1, 0), $urandom_range(K - 1, 0),
                      {$urandom, $urandom, $urandom, $urandom});
            end
          end
        end
      end
      step();
    end
    clear_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
